dlsc_pcie_s6_inbound_header: RTL and testbench

DLSC_PCIE_S6_INBOUND_HEADER -- requirements
Module: dlsc_pcie_s6_inbound_header

---
 rtl/dlsc_pcie_s6_inbound_header_pkg.sv | 44 ++++
 rtl/dlsc_pcie_s6_inbound_hdr_decode.sv | 41 ++++
 rtl/dlsc_pcie_s6_inbound_header.sv | 203 ++++++++++++++++++++
 tb/tb_dlsc_pcie_s6_inbound_header.sv | 643 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_pcie_s6_inbound_header_pkg.sv
// Shared TLP header codes, DW field positions and FSM encoding
// for the Spartan-6 inbound header parser.
package dlsc_pcie_s6_inbound_header_pkg;

  localparam logic [4:0] TYPE_MEM   = 5'b00000;
  localparam logic [1:0] FMT_3DW_ND = 2'b00;
  localparam logic [1:0] FMT_4DW_ND = 2'b01;
  localparam logic [1:0] FMT_3DW_D  = 2'b10;
  localparam logic [1:0] FMT_4DW_D  = 2'b11;

  localparam int FMT_LSB  = 29;
  localparam int TYPE_LSB = 24;
  localparam int TC_LSB   = 20;
  localparam int ATTR_LSB = 12;
  localparam int LEN_LSB  = 0;

  localparam int ID_LSB   = 16;
  localparam int TAG_LSB  = 8;
  localparam int LBE_LSB  = 4;
  localparam int FBE_LSB  = 0;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_DATA,
    ST_DROP
  } state_t;

  typedef enum logic [2:0] {
    K_MRD32,
    K_MRD64,
    K_MWR32,
    K_MWR64,
    K_OTHER
  } kind_t;

  // TRN is big-endian; the payload side is little-endian
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_inbound_hdr_decode.sv
// Classifies fmt/type of an inbound TLP and checks that a 64-bit
// address upper DW fits in the retained address width.
module dlsc_pcie_s6_inbound_hdr_decode
  import dlsc_pcie_s6_inbound_header_pkg::*;
#(
  parameter int ADDR = 32
) (
  input  logic [1:0]  fmt,
  input  logic [4:0]  typ,
  input  logic [31:0] addr_hi,
  output logic        supported,
  output logic        is_write,
  output logic        is_4dw,
  output logic        addr_ok
);

  localparam int SH = (ADDR > 32) ? ADDR - 32 : 0;

  kind_t kind;

  always_comb begin
    kind = K_OTHER;
    if (typ == TYPE_MEM) begin
      unique case (fmt)
        FMT_3DW_ND: kind = K_MRD32;
        FMT_4DW_ND: kind = K_MRD64;
        FMT_3DW_D:  kind = K_MWR32;
        FMT_4DW_D:  kind = K_MWR64;
        default:    kind = K_OTHER;
      endcase
    end
  end

  assign supported = (kind != K_OTHER);
  assign is_write  = (kind == K_MWR32) || (kind == K_MWR64);
  assign is_4dw    = (kind == K_MRD64) || (kind == K_MWR64);

  // shifting by 32 leaves zero, so ADDR=64 always passes
  assign addr_ok = ((addr_hi >> SH) == 32'd0);

endmodule

// File: rtl/dlsc_pcie_s6_inbound_header.sv
// Parses inbound Spartan-6 TRN memory request headers and passes
// write payload through byte-swapped to little-endian.
module dlsc_pcie_s6_inbound_header
  import dlsc_pcie_s6_inbound_header_pkg::*;
#(
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     trn_rd,
  input  logic            trn_rsof_n,
  input  logic            trn_reof_n,
  input  logic            trn_rsrc_rdy_n,
  output logic            trn_rdst_rdy_n,
  input  logic            tlp_h_ready,
  output logic            tlp_h_valid,
  output logic            tlp_h_write,
  output logic [ADDR-3:0] tlp_h_addr,
  output logic [9:0]      tlp_h_len,
  output logic [3:0]      tlp_h_be_first,
  output logic [3:0]      tlp_h_be_last,
  output logic [15:0]     tlp_h_id,
  output logic [7:0]      tlp_h_tag,
  output logic [2:0]      tlp_h_tc,
  output logic [1:0]      tlp_h_attr,
  input  logic            tlp_d_ready,
  output logic            tlp_d_valid,
  output logic [31:0]     tlp_d_data,
  output logic            tlp_d_last,
  output logic            err_unsupported,
  output logic            err_malformed
);

  state_t      st;
  logic        acc;
  logic        sof;
  logic        eof;
  logic        rdy_n;
  logic        in_data;
  logic        is_4dw;
  logic [31:0] addr_hi;
  logic [10:0] cnt;
  logic [10:0] cnt_nx;
  logic [10:0] len_n;
  logic [61:0] addr_full;
  logic        dec_sup;
  logic        dec_wr;
  logic        dec_4dw;
  logic        dec_hi_ok;

  dlsc_pcie_s6_inbound_hdr_decode #(
    .ADDR (ADDR)
  ) u_decode (
    .fmt       (trn_rd[FMT_LSB +: 2]),
    .typ       (trn_rd[TYPE_LSB +: 5]),
    .addr_hi   (trn_rd),
    .supported (dec_sup),
    .is_write  (dec_wr),
    .is_4dw    (dec_4dw),
    .addr_ok   (dec_hi_ok)
  );

  assign sof = !trn_rsof_n;
  assign eof = !trn_reof_n;

  always_comb begin
    rdy_n = 1'b0;
    unique case (st)
      ST_HDR0: rdy_n = tlp_h_valid;
      ST_DATA: rdy_n = !tlp_d_ready;
      default: rdy_n = 1'b0;
    endcase
  end

  assign trn_rdst_rdy_n = rdy_n;
  assign acc            = !trn_rsrc_rdy_n && !rdy_n;

  // a zero length field means 1024 DWs
  assign len_n     = (tlp_h_len == 10'd0) ? 11'd1024
                                          : {1'b0, tlp_h_len};
  assign cnt_nx    = cnt + 11'd1;
  assign addr_full = {addr_hi, trn_rd[31:2]};

  assign in_data     = (st == ST_DATA);
  assign tlp_d_valid = in_data && !trn_rsrc_rdy_n;
  assign tlp_d_data  = bswap32(trn_rd);
  assign tlp_d_last  = in_data && (eof || (cnt_nx == len_n));

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= ST_HDR0;
      tlp_h_valid     <= 1'b0;
      tlp_h_write     <= 1'b0;
      tlp_h_addr      <= '0;
      tlp_h_len       <= '0;
      tlp_h_be_first  <= '0;
      tlp_h_be_last   <= '0;
      tlp_h_id        <= '0;
      tlp_h_tag       <= '0;
      tlp_h_tc        <= '0;
      tlp_h_attr      <= '0;
      err_unsupported <= 1'b0;
      err_malformed   <= 1'b0;
      is_4dw          <= 1'b0;
      addr_hi         <= '0;
      cnt             <= '0;
    end else begin
      err_unsupported <= 1'b0;
      err_malformed   <= 1'b0;
      if (tlp_h_valid && tlp_h_ready) begin
        tlp_h_valid <= 1'b0;
      end
      if (acc) begin
        unique case (st)
          ST_HDR0: begin
            if (!sof) begin
              err_malformed <= 1'b1;
            end else begin
              tlp_h_tc    <= trn_rd[TC_LSB +: 3];
              tlp_h_attr  <= trn_rd[ATTR_LSB +: 2];
              tlp_h_len   <= trn_rd[LEN_LSB +: 10];
              tlp_h_write <= dec_wr;
              is_4dw      <= dec_4dw;
              if (!dec_sup) begin
                err_unsupported <= 1'b1;
                st <= eof ? ST_HDR0 : ST_DROP;
              end else if (eof) begin
                err_malformed <= 1'b1;
              end else begin
                st <= ST_HDR1;
              end
            end
          end
          ST_HDR1: begin
            tlp_h_id       <= trn_rd[ID_LSB +: 16];
            tlp_h_tag      <= trn_rd[TAG_LSB +: 8];
            tlp_h_be_last  <= trn_rd[LBE_LSB +: 4];
            tlp_h_be_first <= trn_rd[FBE_LSB +: 4];
            addr_hi        <= '0;
            if (eof) begin
              err_malformed <= 1'b1;
              st <= ST_HDR0;
            end else begin
              st <= ST_HDR2;
            end
          end
          ST_HDR2, ST_HDR3: begin
            if (st == ST_HDR2 && is_4dw) begin
              if (!dec_hi_ok) begin
                err_unsupported <= 1'b1;
                st <= eof ? ST_HDR0 : ST_DROP;
              end else if (eof) begin
                err_malformed <= 1'b1;
                st <= ST_HDR0;
              end else begin
                addr_hi <= trn_rd;
                st <= ST_HDR3;
              end
            end else begin
              tlp_h_addr <= addr_full[ADDR-3:0];
              if (tlp_h_write && eof) begin
                // a write with no payload beat is discarded
                err_malformed <= 1'b1;
                st <= ST_HDR0;
              end else begin
                tlp_h_valid <= 1'b1;
                if (tlp_h_write) begin
                  st <= ST_DATA;
                end else if (eof) begin
                  st <= ST_HDR0;
                end else begin
                  err_malformed <= 1'b1;
                  st <= ST_DROP;
                end
              end
            end
          end
          ST_DATA: begin
            cnt <= cnt_nx;
            if (eof) begin
              if (cnt_nx != len_n) begin
                err_malformed <= 1'b1;
              end
              cnt <= '0;
              st  <= ST_HDR0;
            end else if (cnt_nx == len_n) begin
              err_malformed <= 1'b1;
              cnt <= '0;
              st  <= ST_DROP;
            end
          end
          ST_DROP: begin
            if (eof) begin
              st <= ST_HDR0;
            end
          end
          default: st <= ST_HDR0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_header.sv
// Randomized self-checking bench for the inbound header parser,
// compared against a TLP-level reference model.
module tb_dlsc_pcie_s6_inbound_header;

  localparam int ADDR = 32;

  typedef struct packed {
    logic        write;
    logic [29:0] addr;
    logic [9:0]  len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [15:0] id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } hdr_t;

  logic            clk;
  logic            rst;
  logic [31:0]     trn_rd;
  logic            trn_rsof_n;
  logic            trn_reof_n;
  logic            trn_rsrc_rdy_n;
  logic            trn_rdst_rdy_n;
  logic            tlp_h_ready;
  logic            tlp_h_valid;
  logic            tlp_h_write;
  logic [ADDR-3:0] tlp_h_addr;
  logic [9:0]      tlp_h_len;
  logic [3:0]      tlp_h_be_first;
  logic [3:0]      tlp_h_be_last;
  logic [15:0]     tlp_h_id;
  logic [7:0]      tlp_h_tag;
  logic [2:0]      tlp_h_tc;
  logic [1:0]      tlp_h_attr;
  logic            tlp_d_ready;
  logic            tlp_d_valid;
  logic [31:0]     tlp_d_data;
  logic            tlp_d_last;
  logic            err_unsupported;
  logic            err_malformed;

  int checks = 0;
  int errors = 0;

  hdr_t        hq[$];
  hdr_t        exp_hq[$];
  logic [32:0] dq[$];
  logic [32:0] exp_dq[$];
  logic [31:0] tx[$];
  int          n_unsup = 0;
  int          n_mal = 0;

  bit h_hold = 0;
  bit h_rand = 0;
  bit d_rand = 0;
  bit gaps = 0;

  dlsc_pcie_s6_inbound_header #(
    .ADDR (ADDR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trn_rd          (trn_rd),
    .trn_rsof_n      (trn_rsof_n),
    .trn_reof_n      (trn_reof_n),
    .trn_rsrc_rdy_n  (trn_rsrc_rdy_n),
    .trn_rdst_rdy_n  (trn_rdst_rdy_n),
    .tlp_h_ready     (tlp_h_ready),
    .tlp_h_valid     (tlp_h_valid),
    .tlp_h_write     (tlp_h_write),
    .tlp_h_addr      (tlp_h_addr),
    .tlp_h_len       (tlp_h_len),
    .tlp_h_be_first  (tlp_h_be_first),
    .tlp_h_be_last   (tlp_h_be_last),
    .tlp_h_id        (tlp_h_id),
    .tlp_h_tag       (tlp_h_tag),
    .tlp_h_tc        (tlp_h_tc),
    .tlp_h_attr      (tlp_h_attr),
    .tlp_d_ready     (tlp_d_ready),
    .tlp_d_valid     (tlp_d_valid),
    .tlp_d_data      (tlp_d_data),
    .tlp_d_last      (tlp_d_last),
    .err_unsupported (err_unsupported),
    .err_malformed   (err_malformed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tlp_h_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tlp_h_ready = !h_hold && (!h_rand || ($urandom_range(0, 2) != 0));
    end
  end

  initial begin
    tlp_d_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tlp_d_ready = !d_rand || ($urandom_range(0, 3) != 0);
    end
  end

  // observed traffic, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (tlp_h_valid && tlp_h_ready)
        hq.push_back({tlp_h_write, tlp_h_addr, tlp_h_len,
                      tlp_h_be_first, tlp_h_be_last, tlp_h_id,
                      tlp_h_tag, tlp_h_tc, tlp_h_attr});
      if (tlp_d_valid && tlp_d_ready)
        dq.push_back({tlp_d_last, tlp_d_data});
      if (err_unsupported) n_unsup++;
      if (err_malformed) n_mal++;
    end
  end

  function automatic logic [31:0] swap_ref(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  function automatic hdr_t rand_hdr(input logic wr, input logic [9:0] len);
    hdr_t h;
    h.write = wr;
    h.addr  = '0;
    h.len   = len;
    h.fbe   = 4'($urandom);
    h.lbe   = 4'($urandom);
    h.id    = 16'($urandom);
    h.tag   = 8'($urandom);
    h.tc    = 3'($urandom);
    h.attr  = 2'($urandom);
    return h;
  endfunction

  function automatic void push_hdr(input logic [1:0] fmt,
                                   input logic [4:0] typ,
                                   input hdr_t h,
                                   input logic [63:0] a);
    tx.push_back({1'b0, fmt, typ, 1'b0, h.tc, 4'b0, 2'b0,
                  h.attr, 2'b0, h.len});
    tx.push_back({h.id, h.tag, h.lbe, h.fbe});
    if (fmt[0]) tx.push_back(a[63:32]);
    tx.push_back({a[31:2], 2'b00});
  endfunction

  task automatic idle();
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit with_sof, input bit with_eof);
    int n;
    int w;
    n = tx.size();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        idle();
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      trn_rd         = tx[i];
      trn_rsof_n     = !(with_sof && i == 0);
      trn_reof_n     = !(with_eof && i == n - 1);
      trn_rsrc_rdy_n = 1'b0;
      w = 0;
      @(negedge clk);
      while (trn_rdst_rdy_n && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (trn_rdst_rdy_n) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat %0d: rdst_rdy_n=1, required 0", i);
        idle();
        return;
      end
      @(posedge clk);
      #1;
    end
    idle();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tlp_h_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_h_valid: got %b, required 0", tlp_h_valid);
    end
    checks++;
    if (tlp_d_valid !== 1'b0 || tlp_d_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_d: got valid %b last %b, required 0 0",
               tlp_d_valid, tlp_d_last);
    end
    checks++;
    if ({err_unsupported, err_malformed} !== 2'b00) begin
      errors++;
      $display("FAIL reset_err: got %b%b, required 00",
               err_unsupported, err_malformed);
    end
    checks++;
    if (trn_rdst_rdy_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdst: got %b, required 0", trn_rdst_rdy_n);
    end
    checks++;
    if ({tlp_h_write, tlp_h_addr, tlp_h_len, tlp_h_id, tlp_h_tag,
         tlp_h_be_first, tlp_h_be_last, tlp_h_tc, tlp_h_attr} !== '0) begin
      errors++;
      $display("FAIL reset_fields: addr %h len %h id %h, required 0",
               tlp_h_addr, tlp_h_len, tlp_h_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle(2);
  endtask

  task automatic test_mrd32();
    hdr_t h;
    int hb, db, ub, mb;
    hb = hq.size(); db = dq.size(); ub = n_unsup; mb = n_mal;
    h = rand_hdr(1'b0, 10'd1);
    h.tag  = 8'h05;
    h.addr = 30'h0400_0010;
    tx.delete();
    push_hdr(2'b00, 5'b00000, h, 64'h0000_0000_1000_0040);
    send(1'b1, 1'b1);
    settle(6);
    checks++;
    if (hq.size() - hb !== 1) begin
      errors++;
      $display("FAIL mrd32_count: got %0d headers, required 1", hq.size() - hb);
    end else begin
      checks++;
      if (hq[hb] !== h) begin
        errors++;
        $display("FAIL mrd32_hdr: got %h, required %h", hq[hb], h);
      end
    end
    checks++;
    if (dq.size() - db !== 0) begin
      errors++;
      $display("FAIL mrd32_data: got %0d beats, required 0", dq.size() - db);
    end
    checks++;
    if (n_unsup - ub !== 0 || n_mal - mb !== 0) begin
      errors++;
      $display("FAIL mrd32_err: got unsup %0d mal %0d, required 0 0",
               n_unsup - ub, n_mal - mb);
    end
  endtask

  task automatic test_mwr64_hold();
    hdr_t h, r;
    logic [31:0] a, pd[4];
    int hb, db, mb;
    hb = hq.size(); db = dq.size(); mb = n_mal;
    h = rand_hdr(1'b1, 10'd4);
    a = $urandom;
    h.addr = a[31:2];
    tx.delete();
    push_hdr(2'b11, 5'b00000, h, {32'h0, a});
    for (int i = 0; i < 4; i++) begin
      pd[i] = $urandom;
      tx.push_back(pd[i]);
    end
    h_hold = 1;
    send(1'b1, 1'b1);
    r = rand_hdr(1'b0, 10'($urandom_range(1, 64)));
    a = $urandom;
    r.addr = a[31:2];
    tx.delete();
    push_hdr(2'b00, 5'b00000, r, {32'h0, a});
    fork
      send(1'b1, 1'b1);
      begin
        checks++;
        if (hq.size() - hb !== 0 || dq.size() - db !== 4) begin
          errors++;
          $display("FAIL mwr64_early_data: got %0d hdr %0d beats, required 0 4",
                   hq.size() - hb, dq.size() - db);
        end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (trn_rdst_rdy_n !== 1'b1) begin
            errors++;
            $display("FAIL mwr64_stall cyc %0d: rdst_rdy_n=%b, required 1",
                     k, trn_rdst_rdy_n);
          end
        end
        h_hold = 0;
      end
    join
    settle(6);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dq[db+i] !== {i == 3, swap_ref(pd[i])}) begin
        errors++;
        $display("FAIL mwr64_beat%0d: got %h, required %h",
                 i, dq[db+i], {i == 3, swap_ref(pd[i])});
      end
    end
    checks++;
    if (hq.size() - hb !== 2) begin
      errors++;
      $display("FAIL mwr64_hcount: got %0d, required 2", hq.size() - hb);
    end else begin
      checks++;
      if (hq[hb] !== h || hq[hb+1] !== r) begin
        errors++;
        $display("FAIL mwr64_hdrs: got %h %h, required %h %h",
                 hq[hb], hq[hb+1], h, r);
      end
    end
    checks++;
    if (n_mal - mb !== 0) begin
      errors++;
      $display("FAIL mwr64_mal: got %0d, required 0", n_mal - mb);
    end
  endtask

  task automatic test_mwr32_1024();
    hdr_t h;
    logic [31:0] a, d;
    int hb, db, mb, bad, nlast;
    hb = hq.size(); db = dq.size(); mb = n_mal;
    exp_dq.delete();
    h = rand_hdr(1'b1, 10'd0);
    a = $urandom;
    h.addr = a[31:2];
    tx.delete();
    push_hdr(2'b10, 5'b00000, h, {32'h0, a});
    for (int i = 0; i < 1024; i++) begin
      d = $urandom;
      tx.push_back(d);
      exp_dq.push_back({i == 1023, swap_ref(d)});
    end
    gaps = 1; d_rand = 1;
    send(1'b1, 1'b1);
    gaps = 0; d_rand = 0;
    settle(6);
    checks++;
    if (dq.size() - db !== 1024) begin
      errors++;
      $display("FAIL len1024_count: got %0d beats, required 1024",
               dq.size() - db);
    end
    bad = 0;
    nlast = 0;
    for (int i = 0; i < 1024 && db + i < dq.size(); i++) begin
      if (dq[db+i] !== exp_dq[i]) bad++;
      if (dq[db+i][32]) nlast++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL len1024_data: got %0d wrong beats, required 0", bad);
    end
    checks++;
    if (nlast !== 1) begin
      errors++;
      $display("FAIL len1024_last: got %0d last beats, required 1", nlast);
    end
    checks++;
    if (n_mal - mb !== 0 || hq.size() - hb !== 1) begin
      errors++;
      $display("FAIL len1024_hdr: got mal %0d hdrs %0d, required 0 1",
               n_mal - mb, hq.size() - hb);
    end
  endtask

  task automatic test_cpld();
    hdr_t h;
    int hb, db, ub, mb;
    hb = hq.size(); db = dq.size(); ub = n_unsup; mb = n_mal;
    h = rand_hdr(1'b1, 10'd3);
    tx.delete();
    push_hdr(2'b10, 5'b01010, h, {32'h0, $urandom});
    for (int i = 0; i < 3; i++) tx.push_back($urandom);
    send(1'b1, 1'b1);
    settle(6);
    checks++;
    if (n_unsup - ub !== 1) begin
      errors++;
      $display("FAIL cpld_unsup: got %0d pulses, required 1", n_unsup - ub);
    end
    checks++;
    if (n_mal - mb !== 0 || hq.size() - hb !== 0 || dq.size() - db !== 0) begin
      errors++;
      $display("FAIL cpld_side: got mal %0d hdr %0d beats %0d, required 0 0 0",
               n_mal - mb, hq.size() - hb, dq.size() - db);
    end
  endtask

  task automatic test_short_eof();
    hdr_t h, r;
    logic [31:0] a, pd[2];
    int hb, db, mb;
    hb = hq.size(); db = dq.size(); mb = n_mal;
    h = rand_hdr(1'b1, 10'd4);
    a = $urandom;
    h.addr = a[31:2];
    tx.delete();
    push_hdr(2'b10, 5'b00000, h, {32'h0, a});
    for (int i = 0; i < 2; i++) begin
      pd[i] = $urandom;
      tx.push_back(pd[i]);
    end
    send(1'b1, 1'b1);
    r = rand_hdr(1'b0, 10'($urandom_range(1, 1023)));
    a = $urandom;
    r.addr = a[31:2];
    tx.delete();
    push_hdr(2'b00, 5'b00000, r, {32'h0, a});
    send(1'b1, 1'b1);
    settle(6);
    checks++;
    if (n_mal - mb !== 1) begin
      errors++;
      $display("FAIL short_mal: got %0d pulses, required 1", n_mal - mb);
    end
    checks++;
    if (dq.size() - db !== 2) begin
      errors++;
      $display("FAIL short_count: got %0d beats, required 2", dq.size() - db);
    end else begin
      checks++;
      if (dq[db] !== {1'b0, swap_ref(pd[0])} ||
          dq[db+1] !== {1'b1, swap_ref(pd[1])}) begin
        errors++;
        $display("FAIL short_beats: got %h %h, required %h %h", dq[db],
                 dq[db+1], {1'b0, swap_ref(pd[0])}, {1'b1, swap_ref(pd[1])});
      end
    end
    checks++;
    if (hq.size() - hb !== 2) begin
      errors++;
      $display("FAIL short_hcount: got %0d, required 2", hq.size() - hb);
    end else begin
      checks++;
      if (hq[hb] !== h || hq[hb+1] !== r) begin
        errors++;
        $display("FAIL short_hdrs: got %h %h, required %h %h",
                 hq[hb], hq[hb+1], h, r);
      end
    end
  endtask

  task automatic test_reset_mid();
    hdr_t h, r;
    logic [31:0] a;
    int hb, mb, ub;
    h = rand_hdr(1'b1, 10'd4);
    a = $urandom;
    h.addr = a[31:2];
    tx.delete();
    push_hdr(2'b10, 5'b00000, h, {32'h0, a});
    tx.push_back($urandom);
    h_hold = 1;
    send(1'b1, 1'b0);
    hb = hq.size();
    trn_rd = $urandom;
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rsrc_rdy_n = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (tlp_h_valid !== 1'b0 || trn_rdst_rdy_n !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_valid: got h_valid %b rdst %b, required 0 0",
               tlp_h_valid, trn_rdst_rdy_n);
    end
    checks++;
    if ({tlp_h_write, tlp_h_addr, tlp_h_len, tlp_h_id} !== '0) begin
      errors++;
      $display("FAIL rstmid_fields: got addr %h len %h, required 0",
               tlp_h_addr, tlp_h_len);
    end
    h_hold = 0;
    mb = n_mal; ub = n_unsup;
    @(posedge clk);
    #1;
    tx.delete();
    tx.push_back($urandom);
    tx.push_back($urandom);
    send(1'b0, 1'b1);
    settle(4);
    checks++;
    if (n_mal - mb !== 2 || n_unsup - ub !== 0) begin
      errors++;
      $display("FAIL rstmid_leftover: got mal %0d unsup %0d, required 2 0",
               n_mal - mb, n_unsup - ub);
    end
    r = rand_hdr(1'b0, 10'($urandom_range(1, 1023)));
    a = $urandom;
    r.addr = a[31:2];
    tx.delete();
    push_hdr(2'b01, 5'b00000, r, {32'h0, a});
    send(1'b1, 1'b1);
    settle(6);
    checks++;
    if (hq.size() - hb !== 1) begin
      errors++;
      $display("FAIL rstmid_hcount: got %0d, required 1", hq.size() - hb);
    end else begin
      checks++;
      if (hq[hb] !== r) begin
        errors++;
        $display("FAIL rstmid_mrd: got %h, required %h", hq[hb], r);
      end
    end
  endtask

  task automatic test_random();
    hdr_t h;
    logic [31:0] a, ahi, d;
    logic [1:0] fmt;
    logic [4:0] typ;
    int kind, len, hb, db, ub, mb, xu, bad;
    hb = hq.size(); db = dq.size(); ub = n_unsup; mb = n_mal;
    exp_hq.delete();
    exp_dq.delete();
    xu = 0;
    gaps = 1; h_rand = 1; d_rand = 1;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      len = $urandom_range(1, 8);
      fmt = 2'(kind);
      typ = 5'b00000;
      ahi = 32'h0;
      if (kind == 4) begin
        fmt = 2'b10;
        typ = 5'b01010;
      end
      if (kind == 5) begin
        fmt = 2'b11;
        ahi = $urandom_range(1, 32'hFFFF_FFFF);
      end
      h = rand_hdr(fmt[1], 10'(len));
      a = $urandom;
      h.addr = a[31:2];
      tx.delete();
      push_hdr(fmt, typ, h, {ahi, a});
      if (kind >= 4) xu++;
      else exp_hq.push_back(h);
      if (fmt[1]) begin
        for (int i = 0; i < len; i++) begin
          d = $urandom;
          tx.push_back(d);
          if (kind < 4) exp_dq.push_back({i == len - 1, swap_ref(d)});
        end
      end
      send(1'b1, 1'b1);
    end
    gaps = 0; h_rand = 0; d_rand = 0;
    settle(8);
    checks++;
    if (n_unsup - ub !== xu || n_mal - mb !== 0) begin
      errors++;
      $display("FAIL rand_err: got unsup %0d mal %0d, required %0d 0",
               n_unsup - ub, n_mal - mb, xu);
    end
    checks++;
    if (hq.size() - hb !== exp_hq.size()) begin
      errors++;
      $display("FAIL rand_hcount: got %0d, required %0d",
               hq.size() - hb, exp_hq.size());
    end else begin
      foreach (exp_hq[i]) begin
        checks++;
        if (hq[hb+i] !== exp_hq[i]) begin
          errors++;
          $display("FAIL rand_hdr%0d: got %h, required %h",
                   i, hq[hb+i], exp_hq[i]);
        end
      end
    end
    checks++;
    if (dq.size() - db !== exp_dq.size()) begin
      errors++;
      $display("FAIL rand_dcount: got %0d, required %0d",
               dq.size() - db, exp_dq.size());
    end else begin
      bad = 0;
      foreach (exp_dq[i]) if (dq[db+i] !== exp_dq[i]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rand_data: got %0d wrong beats, required 0", bad);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    trn_rd = '0;
    idle();
    test_reset();
    test_mrd32();
    test_mwr64_hold();
    test_mwr32_1024();
    test_cpld();
    test_short_eof();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
